// File: rtl/m_seq_checker.sv
// m_seq_checker
//
// Receive-side checker for the 7-bit M-sequence test pattern (x^7+x^6+1,
// period 127). The block synchronises a local LFSR to the recovered bit
// stream, confirms the alignment, and then declares lock. While locked it
// flags every bit error and tracks BER statistics. Lock is dropped when a
// window of WINDOW bits contains more than LOSS_THRESH errors.
//
// Build option: define MSEQ_CHK_STATS_EN to include the total_bits /
// total_errs counters and clear_stats. Without it both outputs are tied
// to 0 and clear_stats is ignored. The lock FSM and err_pulse are the same
// in both builds.
//
// Ports:
//   clk          in   block clock
//   reset        in   synchronous, active-high reset
//   bit_in       in   recovered data bit, sampled when bit_valid=1
//   bit_valid    in   one-cycle strobe per received bit
//   clear_stats  in   synchronous clear of total_bits / total_errs
//   locked       out  high in LOCKED
//   state        out  0 SEARCH, 1 VERIFY, 2 LOCKED
//   err_pulse    out  one-cycle pulse per mismatching bit while LOCKED
//   total_bits   out  bits checked while LOCKED (saturating)
//   total_errs   out  errors detected while LOCKED (saturating)
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | shifting received bits into the LFSR (7 bits to fill it)
// VERIFY  | LFSR fed by received bits; counting correct predictions
// LOCKED  | LFSR free-runs; errors flagged and counted per window

module m_seq_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_stats,
    output logic        locked,
    output logic [1:0]  state,
    output logic        err_pulse,
    output logic [23:0] total_bits,
    output logic [23:0] total_errs
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0]  LOCK_CNT_W    = LOCK_CNT[7:0];
    localparam logic [15:0] WINDOW_W      = WINDOW[15:0];
    localparam logic [15:0] LOSS_THRESH_W = LOSS_THRESH[15:0];

    logic [6:0]  lfsr;
    logic [2:0]  load_cnt;
    logic [7:0]  match_cnt;
    logic [15:0] win_bits;
    logic [15:0] win_errs;

    logic        pred;
    logic        mismatch;
    logic [7:0]  match_nxt;
    logic [15:0] win_bits_nxt;
    logic [15:0] win_errs_nxt;

    assign pred         = lfsr[6] ^ lfsr[5];
    assign mismatch     = bit_in ^ pred;
    assign match_nxt    = match_cnt + 8'd1;
    assign win_bits_nxt = win_bits + 16'd1;
    assign win_errs_nxt = win_errs + {15'd0, mismatch};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lfsr      <= '0;
            load_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                case (state)
                    ST_SEARCH: begin
                        lfsr <= {lfsr[5:0], bit_in};
                        if (load_cnt == 3'd6) begin
                            state     <= ST_VERIFY;
                            load_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + 3'd1;
                        end
                    end
                    ST_VERIFY: begin
                        lfsr <= {lfsr[5:0], bit_in};
                        // An all-zero register predicts zeros forever, so it
                        // would lock onto a dead line; treat it as a miss.
                        if ((lfsr == 7'd0) || mismatch) begin
                            state    <= ST_SEARCH;
                            load_cnt <= '0;
                        end else begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_CNT_W) begin
                                state    <= ST_LOCKED;
                                locked   <= 1'b1;
                                win_bits <= '0;
                                win_errs <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run so received errors never corrupt the reference.
                        lfsr      <= {lfsr[5:0], pred};
                        err_pulse <= mismatch;
                        if (win_bits_nxt == WINDOW_W) begin
                            win_bits <= '0;
                            win_errs <= '0;
                            if (win_errs_nxt > LOSS_THRESH_W) begin
                                state    <= ST_SEARCH;
                                locked   <= 1'b0;
                                load_cnt <= '0;
                            end
                        end else begin
                            win_bits <= win_bits_nxt;
                            win_errs <= win_errs_nxt;
                        end
                    end
                    default: begin
                        state    <= ST_SEARCH;
                        locked   <= 1'b0;
                        load_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef MSEQ_CHK_STATS_EN
    logic count_en;

    assign count_en = bit_valid && (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            total_bits <= '0;
            total_errs <= '0;
        end else if (clear_stats) begin
            total_bits <= '0;
            total_errs <= '0;
        end else begin
            if (count_en && (total_bits != 24'hFFFFFF)) begin
                total_bits <= total_bits + 24'd1;
            end
            if (count_en && mismatch && (total_errs != 24'hFFFFFF)) begin
                total_errs <= total_errs + 24'd1;
            end
        end
    end
`else
    logic unused_clear_stats;

    assign unused_clear_stats = clear_stats;
    assign total_bits         = '0;
    assign total_errs         = '0;
`endif

endmodule

// File: tb/tb_m_seq_checker.sv
module tb_m_seq_checker;

`ifdef MSEQ_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_stats;
    logic        locked;
    logic [1:0]  state;
    logic        err_pulse;
    logic [23:0] total_bits;
    logic [23:0] total_errs;

    int          errors = 0;
    int          checks = 0;
    int          pulses;
    logic [6:0]  gen_s;

    m_seq_checker #(
        .LOCK_CNT(16),
        .WINDOW(64),
        .LOSS_THRESH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .clear_stats(clear_stats),
        .locked(locked),
        .state(state),
        .err_pulse(err_pulse),
        .total_bits(total_bits),
        .total_errs(total_errs)
    );

    always #5 clk = ~clk;

    // Transmit-side M-sequence generator (x^7+x^6+1).
    task automatic next_gen(output logic b);
        b     = gen_s[6] ^ gen_s[5];
        gen_s = {gen_s[5:0], b};
    endtask

    // One valid bit, then 'gap' idle cycles. Outputs sampled 1 time unit
    // after each edge; err_pulse counted on every sampled cycle.
    task automatic send(input logic b, input int gap);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        if (err_pulse) pulses++;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk);
            #1;
            if (err_pulse) pulses++;
        end
    endtask

    task automatic send_gen(input logic inv, input int gap);
        logic b;
        next_gen(b);
        send(b ^ inv, gap);
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_fresh();
        pulse_reset();
        gen_s = 7'h7F;
        for (int i = 0; i < 23; i++) send_gen(1'b0, 0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_fresh: locked=%b expected 1", locked);
        end
        pulses = 0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state: state=%0d expected 0", state); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: locked=%b expected 0", locked); end
        checks++;
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err: err_pulse=%b expected 0", err_pulse); end
        checks++;
        if (total_bits !== 24'd0 || total_errs !== 24'd0) begin
            errors++;
            $display("FAIL reset_totals: bits=%0d errs=%0d expected 0 0", total_bits, total_errs);
        end
    endtask

    task automatic test_clean_lock();
        logic [23:0] exp_bits;
        pulse_reset();
        gen_s  = 7'h7F;
        pulses = 0;
        for (int i = 1; i <= 33; i++) begin
            send_gen(1'b0, 127);
            if (i == 7) begin
                checks++;
                if (state !== 2'd1) begin errors++; $display("FAIL verify_entry: state=%0d expected 1", state); end
            end
            if (i == 22) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b expected 0 after bit 22", locked); end
            end
            if (i == 23) begin
                checks++;
                if (locked !== 1'b1 || state !== 2'd2) begin
                    errors++;
                    $display("FAIL lock_rise: locked=%b state=%0d expected 1 2 after bit 23", locked, state);
                end
            end
        end
        exp_bits = STATS ? 24'd10 : 24'd0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
        checks++;
        if (total_bits !== exp_bits) begin errors++; $display("FAIL clean_total_bits: got %0d expected %0d", total_bits, exp_bits); end
    endtask

    task automatic test_single_error();
        logic [23:0] exp_bits, exp_errs;
        pulses = 0;
        for (int i = 0; i < 20; i++) send_gen(i == 5, 1);
        exp_bits = STATS ? 24'd30 : 24'd0;
        exp_errs = STATS ? 24'd1 : 24'd0;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        checks++;
        if (total_errs !== exp_errs) begin errors++; $display("FAIL single_total_errs: got %0d expected %0d", total_errs, exp_errs); end
        checks++;
        if (total_bits !== exp_bits) begin errors++; $display("FAIL single_total_bits: got %0d expected %0d", total_bits, exp_bits); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: locked=%b expected 1", locked); end
    endtask

    task automatic test_burst_loss();
        logic [23:0] exp_errs;
        lock_fresh();
        for (int i = 0; i < 64; i++) begin
            send_gen((i >= 10) && (i < 19), 0);
            if (i == 62) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL burst_hold: locked=%b expected 1 before window end", locked); end
            end
        end
        exp_errs = STATS ? 24'd9 : 24'd0;
        checks++;
        if (locked !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL burst_drop: locked=%b state=%0d expected 0 0", locked, state);
        end
        checks++;
        if (pulses != 9) begin errors++; $display("FAIL burst_pulses: got %0d expected 9", pulses); end
        for (int i = 1; i <= 23; i++) begin
            send_gen(1'b0, 0);
            if (i == 22) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: locked=%b expected 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock: locked=%b expected 1", locked); end
        checks++;
        if (total_errs !== exp_errs) begin errors++; $display("FAIL burst_total_errs: got %0d expected %0d", total_errs, exp_errs); end
    endtask

    task automatic test_threshold();
        logic [23:0] exp_errs;
        lock_fresh();
        for (int i = 0; i < 64; i++) send_gen(((i >= 50) && (i < 57)) || (i == 63), 0);
        exp_errs = STATS ? 24'd8 : 24'd0;
        checks++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            errors++;
            $display("FAIL thresh_hold: locked=%b state=%0d expected 1 2", locked, state);
        end
        checks++;
        if (pulses != 8) begin errors++; $display("FAIL thresh_pulses: got %0d expected 8", pulses); end
        checks++;
        if (total_errs !== exp_errs) begin errors++; $display("FAIL thresh_total_errs: got %0d expected %0d", total_errs, exp_errs); end
        // Next window starts from zero errors: one error must not drop lock.
        for (int i = 0; i < 64; i++) send_gen(i == 63, 0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL thresh_next_window: locked=%b expected 1", locked); end
    endtask

    task automatic test_all_zero();
        int max_state = 0;
        int saw_lock  = 0;
        pulse_reset();
        for (int i = 0; i < 1000; i++) begin
            send(1'b0, 0);
            if (int'(state) > max_state) max_state = int'(state);
            if (locked) saw_lock++;
        end
        checks++;
        if (saw_lock != 0) begin errors++; $display("FAIL zero_locked: lock seen %0d cycles expected 0", saw_lock); end
        checks++;
        if (max_state >= 2) begin errors++; $display("FAIL zero_state: max state=%0d expected <2", max_state); end
    endtask

    task automatic test_reset_clear();
        logic b;
        lock_fresh();
        for (int i = 0; i < 5; i++) send_gen(i == 2, 0);
        pulse_reset();
        checks++;
        if (state !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: state=%0d locked=%b expected 0 0", state, locked);
        end
        checks++;
        if (total_bits !== 24'd0 || total_errs !== 24'd0) begin
            errors++;
            $display("FAIL midreset_totals: bits=%0d errs=%0d expected 0 0", total_bits, total_errs);
        end
        lock_fresh();
        for (int i = 0; i < 3; i++) send_gen(1'b0, 0);
        next_gen(b);
        clear_stats = 1'b1;
        send(~b, 0);
        clear_stats = 1'b0;
        checks++;
        if (total_errs !== 24'd0 || total_bits !== 24'd0) begin
            errors++;
            $display("FAIL clear_priority: bits=%0d errs=%0d expected 0 0", total_bits, total_errs);
        end
        checks++;
        if (err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clear_lock: err_pulse=%b locked=%b expected 1 1", err_pulse, locked);
        end
        send_gen(1'b1, 0);
        checks++;
        if (total_errs !== (STATS ? 24'd1 : 24'd0)) begin
            errors++;
            $display("FAIL clear_resume: errs=%0d expected %0d", total_errs, STATS ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_loss();
        test_threshold();
        test_all_zero();
        test_reset_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
